// File: rtl/router_port_drain.sv
// Drains one router output port: reads header, payload and parity, re-checks XOR parity, reports status per packet.
// byte_valid follows read_enb by 1 cycle; reads only while vld_out=1, aborts after STALL_TIMEOUT low cycles.
module router_port_drain #(
  parameter int START_DELAY   = 0,
  parameter int STALL_TIMEOUT = 32,
  parameter int CNT_W         = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             enable,
  input  logic             vld_out,
  input  logic [7:0]       data_in,
  output logic             read_enb,
  output logic [7:0]       byte_out,
  output logic             byte_valid,
  output logic             sop,
  output logic             eop,
  output logic [7:0]       hdr_out,
  output logic             pkt_done,
  output logic             parity_err,
  output logic             trunc_err,
  output logic             busy,
  output logic [CNT_W-1:0] pkt_count,
  output logic [CNT_W-1:0] err_count
);
  localparam int DW = (START_DELAY > 1) ? $clog2(START_DELAY + 1) : 1;
  localparam int SW = $clog2(STALL_TIMEOUT + 1);

  typedef enum logic [2:0] {IDLE, HDR_RD, HDR_CAP, STREAM, DONE} state_t;

  state_t           state_q, state_d;
  logic [DW-1:0]    dly_q, dly_d;
  logic [SW-1:0]    stall_q, stall_d;
  logic [6:0]       target_q, target_d;
  logic [6:0]       issued_q, issued_d;
  logic [6:0]       rcv_q, rcv_d;
  logic [7:0]       par_q, par_d;
  logic [7:0]       hdr_q, hdr_d;
  logic             perr_q, perr_d;
  logic             trunc_q, trunc_d;
  logic [CNT_W-1:0] pkt_q, pkt_d;
  logic [CNT_W-1:0] err_q, err_d;
  logic             rd_q;
  logic             dly_done, stall_hit, last_byte;

  // The header read lands START_DELAY cycles after entering HDR_RD.
  assign dly_done = (dly_q == '0);

  always_comb begin
    state_d   = state_q;
    dly_d     = dly_q;
    stall_d   = '0;
    target_d  = target_q;
    issued_d  = issued_q;
    rcv_d     = rcv_q;
    par_d     = par_q;
    hdr_d     = hdr_q;
    perr_d    = perr_q;
    trunc_d   = trunc_q;
    pkt_d     = pkt_q;
    err_d     = err_q;
    last_byte = 1'b0;
    stall_hit = 1'b0;

    read_enb = vld_out && (((state_q == HDR_RD) && dly_done) ||
                           ((state_q == STREAM) && (issued_q < target_q)));

    // Abort decision is taken on the (STALL_TIMEOUT-1)th low cycle so pkt_done
    // coincides with the STALL_TIMEOUT-th consecutive low cycle.
    if ((state_q == HDR_RD) || (state_q == STREAM)) begin
      stall_d   = vld_out ? '0 : stall_q + 1'b1;
      stall_hit = !vld_out && (stall_d == SW'(STALL_TIMEOUT - 1));
    end

    if (read_enb) issued_d = issued_q + 7'd1;

    case (state_q)
      IDLE: begin
        if (vld_out && enable) begin
          state_d = HDR_RD;
          dly_d   = DW'(START_DELAY);
          perr_d  = 1'b0;
          trunc_d = 1'b0;
        end
      end
      HDR_RD: begin
        if (!dly_done) dly_d = dly_q - 1'b1;
        if (read_enb) begin
          state_d = HDR_CAP;
        end else if (stall_hit) begin
          state_d = DONE;
          trunc_d = 1'b1;
        end
      end
      HDR_CAP: begin
        hdr_d    = data_in;
        par_d    = data_in;
        target_d = {1'b0, data_in[7:2]} + 7'd1;
        issued_d = '0;
        rcv_d    = '0;
        state_d  = STREAM;
      end
      STREAM: begin
        if (rd_q) begin
          rcv_d     = rcv_q + 7'd1;
          last_byte = (rcv_d == target_q);
          if (last_byte) begin
            perr_d  = (par_q != data_in);
            state_d = DONE;
          end else begin
            par_d = par_q ^ data_in;
          end
        end
        if (!last_byte && stall_hit) begin
          state_d = DONE;
          trunc_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
        pkt_d   = pkt_q + 1'b1;
        if (perr_q || trunc_q) err_d = err_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= IDLE;
      dly_q    <= '0;
      stall_q  <= '0;
      target_q <= '0;
      issued_q <= '0;
      rcv_q    <= '0;
      par_q    <= '0;
      hdr_q    <= '0;
      perr_q   <= 1'b0;
      trunc_q  <= 1'b0;
      pkt_q    <= '0;
      err_q    <= '0;
      rd_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      dly_q    <= dly_d;
      stall_q  <= stall_d;
      target_q <= target_d;
      issued_q <= issued_d;
      rcv_q    <= rcv_d;
      par_q    <= par_d;
      hdr_q    <= hdr_d;
      perr_q   <= perr_d;
      trunc_q  <= trunc_d;
      pkt_q    <= pkt_d;
      err_q    <= err_d;
      rd_q     <= read_enb;
    end
  end

  // Router data is valid the cycle after read_enb, so it is forwarded directly while rd_q is set.
  assign byte_valid = rd_q;
  assign byte_out   = rd_q ? data_in : 8'h00;
  assign sop        = rd_q && (state_q == HDR_CAP);
  assign eop        = last_byte;
  assign hdr_out    = hdr_q;
  assign pkt_done   = (state_q == DONE);
  assign parity_err = pkt_done && perr_q;
  assign trunc_err  = pkt_done && trunc_q;
  assign busy       = (state_q != IDLE);
  assign pkt_count  = pkt_q;
  assign err_count  = err_q;

endmodule

// File: tb/tb_router_port_drain.sv
// Bench for router_port_drain: queue-based router model feeds packets, monitor scores bytes and status.
module tb_router_port_drain;
  localparam int SD = 20;
  localparam int ST = 32;
  localparam int CW = 16;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          enable = 1'b0;
  logic          vld_out = 1'b0;
  logic [7:0]    data_in = 8'h00;
  logic          read_enb, byte_valid, sop, eop, pkt_done, parity_err, trunc_err, busy;
  logic [7:0]    byte_out, hdr_out;
  logic [CW-1:0] pkt_count, err_count;

  typedef struct { logic [7:0] dat; bit sop; bit eop; } exp_b_t;
  typedef struct { logic [7:0] hdr; bit perr; bit trunc; int nbytes; } exp_s_t;

  exp_b_t        eb_q[$];
  exp_s_t        es_q[$];
  logic [7:0]    rq[$];
  int            n_chk = 0;
  int            n_err = 0;
  int            cyc = 0;
  logic [CW-1:0] mc_pkt = '0;
  logic [CW-1:0] mc_err = '0;

  router_port_drain #(.START_DELAY(SD), .STALL_TIMEOUT(ST), .CNT_W(CW)) dut (
    .clk(clk), .resetn(resetn), .enable(enable), .vld_out(vld_out), .data_in(data_in),
    .read_enb(read_enb), .byte_out(byte_out), .byte_valid(byte_valid), .sop(sop), .eop(eop),
    .hdr_out(hdr_out), .pkt_done(pkt_done), .parity_err(parity_err), .trunc_err(trunc_err),
    .busy(busy), .pkt_count(pkt_count), .err_count(err_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Router port: data_in appears the cycle after read_enb, vld_out = FIFO not empty.
  initial begin : router_model
    logic re_s;
    re_s = 1'b0;
    forever begin
      @(negedge clk);
      re_s = read_enb;
      @(posedge clk);
      #1;
      if (re_s && rq.size() > 0) data_in = rq.pop_front();
      #2;
      vld_out = (rq.size() != 0);
    end
  end

  initial begin : monitor
    bit     ref_idle;
    bit     hdr_seen;
    int     hdr_cyc, reads, nb, last_vld, eop_cyc;
    exp_b_t b;
    exp_s_t s;
    ref_idle = 1'b1; hdr_seen = 1'b0; hdr_cyc = 0; reads = 0; nb = 0; last_vld = 0; eop_cyc = -10;
    forever begin
      @(negedge clk);
      cyc++;
      if (!resetn) begin
        ref_idle = 1'b1; hdr_seen = 1'b0; reads = 0; nb = 0; eop_cyc = -10;
        mc_pkt = '0; mc_err = '0;
      end else begin
        if (vld_out) last_vld = cyc;
        if (ref_idle && vld_out && enable) begin
          ref_idle = 1'b0; hdr_cyc = cyc + 1 + SD; hdr_seen = 1'b0; reads = 0; nb = 0;
        end
        if (read_enb) begin
          chk("read_needs_vld", vld_out, 1);
          chk("read_while_idle", ref_idle, 0);
          if (!ref_idle && !hdr_seen) begin
            chk("hdr_read_cycle", cyc, hdr_cyc);
            hdr_seen = 1'b1;
          end
          reads++;
        end
        if (byte_valid) begin
          nb++;
          chk("byte_expected", eb_q.size() > 0, 1);
          if (eb_q.size() > 0) begin
            b = eb_q.pop_front();
            chk("byte_out", byte_out, b.dat);
            chk("sop", sop, b.sop);
            chk("eop", eop, b.eop);
          end
          if (eop) eop_cyc = cyc;
        end
        if (pkt_done) begin
          chk("status_expected", es_q.size() > 0, 1);
          if (es_q.size() > 0) begin
            s = es_q.pop_front();
            chk("parity_err", parity_err, s.perr);
            chk("trunc_err", trunc_err, s.trunc);
            chk("hdr_out", hdr_out, s.hdr);
            chk("pkt_count_at_done", pkt_count, mc_pkt);
            chk("err_count_at_done", err_count, mc_err);
            chk("reads_per_pkt", reads, s.nbytes);
            chk("bytes_per_pkt", nb, s.nbytes);
            if (s.trunc) chk("stall_abort_delay", cyc - last_vld, ST);
            else         chk("done_after_eop", cyc - eop_cyc, 1);
            mc_pkt = mc_pkt + 1'b1;
            if (s.perr || s.trunc) mc_err = mc_err + 1'b1;
          end
          ref_idle = 1'b1;
        end
      end
    end
  end

  task automatic wait_empty(input int budget);
    int t = 0;
    while (rq.size() != 0 && t < budget) begin step(1); t++; end
    chk("fifo_emptied_in_time", t < budget, 1);
  endtask

  task automatic wait_drain(input int budget);
    int t = 0;
    while ((es_q.size() != 0 || rq.size() != 0) && t < budget) begin step(1); t++; end
    chk("drained_in_time", t < budget, 1);
    step(2);
    chk("pkt_count", pkt_count, mc_pkt);
    chk("err_count", err_count, mc_err);
    chk("busy_after_drain", busy, 0);
  endtask

  // gap_at: payload index before which vld_out is held low gap_len cycles; trunc_at: payloads sent before stall.
  task automatic send_pkt(input logic [5:0] len, input logic [1:0] addr, input bit bad,
                          input int gap_at, input int gap_len, input int trunc_at);
    logic [7:0] hdr, par;
    logic [7:0] pl[$];
    exp_b_t     b;
    exp_s_t     s;
    int         n;
    hdr = {len, addr};
    par = hdr;
    for (int i = 0; i < int'(len); i++) begin
      pl.push_back(8'($urandom));
      par = par ^ pl[i];
    end
    if (bad) par = par ^ 8'h01;
    n = (trunc_at >= 0) ? trunc_at : int'(len);
    b.dat = hdr; b.sop = 1'b1; b.eop = 1'b0;
    eb_q.push_back(b);
    for (int i = 0; i < n; i++) begin
      b.dat = pl[i]; b.sop = 1'b0; b.eop = 1'b0;
      eb_q.push_back(b);
    end
    if (trunc_at < 0) begin
      b.dat = par; b.sop = 1'b0; b.eop = 1'b1;
      eb_q.push_back(b);
    end
    s.hdr = hdr; s.perr = bad && (trunc_at < 0); s.trunc = (trunc_at >= 0);
    s.nbytes = (trunc_at >= 0) ? n + 1 : int'(len) + 2;
    es_q.push_back(s);
    rq.push_back(hdr);
    for (int i = 0; i < n; i++) begin
      if (i == gap_at) begin
        wait_empty(600);
        step(gap_len);
      end
      rq.push_back(pl[i]);
    end
    if (trunc_at < 0) rq.push_back(par);
  endtask

  task automatic check_zero(input string tag);
    chk({tag, "_read_enb"}, read_enb, 0);
    chk({tag, "_byte_out"}, byte_out, 0);
    chk({tag, "_byte_valid"}, byte_valid, 0);
    chk({tag, "_sop"}, sop, 0);
    chk({tag, "_eop"}, eop, 0);
    chk({tag, "_hdr_out"}, hdr_out, 0);
    chk({tag, "_pkt_done"}, pkt_done, 0);
    chk({tag, "_parity_err"}, parity_err, 0);
    chk({tag, "_trunc_err"}, trunc_err, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_pkt_count"}, pkt_count, 0);
    chk({tag, "_err_count"}, err_count, 0);
  endtask

  initial begin : watchdog
    #800000;
    $display("FAIL watchdog: simulation time limit exceeded");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int t;
    step(2);
    check_zero("reset");
    resetn = 1'b1;
    enable = 1'b1;
    step(2);
    check_zero("post_reset");

    // len 8 addr 2, good parity; enable dropped mid-packet must not matter
    send_pkt(6'd8, 2'd2, 1'b0, -1, 0, -1);
    step(SD + 5);
    enable = 1'b0;
    wait_drain(500);
    enable = 1'b1;

    // same packet shape, corrupted parity
    send_pkt(6'd8, 2'd2, 1'b1, -1, 0, -1);
    wait_drain(500);

    // len 5, vld_out low 3 cycles after payload byte 2
    send_pkt(6'd5, 2'd1, 1'b0, 2, 3, -1);
    wait_drain(500);

    // stall after 4 payload bytes
    send_pkt(6'd8, 2'd0, 1'b0, -1, 0, 4);
    wait_drain(500);

    // back-to-back packets, vld_out never drops between them
    send_pkt(6'd8, 2'd1, 1'b0, -1, 0, -1);
    send_pkt(6'd5, 2'd2, 1'b0, -1, 0, -1);
    wait_drain(800);

    // reset in the middle of a long stream
    send_pkt(6'd40, 2'd0, 1'b0, -1, 0, -1);
    t = 0;
    while (eb_q.size() > 30 && t < 400) begin step(1); t++; end
    chk("reached_stream", t < 400, 1);
    resetn = 1'b0;
    rq.delete();
    eb_q.delete();
    es_q.delete();
    #1;
    check_zero("mid_reset");
    step(2);
    resetn = 1'b1;
    step(2);
    send_pkt(6'd6, 2'd1, 1'b0, -1, 0, -1);
    wait_drain(500);

    // packet waiting while enable is low must not be touched
    enable = 1'b0;
    send_pkt(6'd3, 2'd2, 1'b0, -1, 0, -1);
    step(40);
    chk("idle_while_disabled", busy, 0);
    enable = 1'b1;
    wait_drain(500);

    for (int k = 0; k < 20; k++) begin
      int ln, gap;
      ln  = (k == 0) ? 0 : (k == 1) ? 63 : int'($urandom_range(0, 63));
      gap = (ln > 0 && $urandom_range(0, 3) == 0) ? int'($urandom_range(0, ln - 1)) : -1;
      send_pkt(6'(ln), 2'($urandom_range(0, 2)), $urandom_range(0, 3) == 0, gap,
               int'($urandom_range(1, 8)), -1);
      if ($urandom_range(0, 2) == 0) begin
        enable = 1'b0;
        step(int'($urandom_range(1, 30)));
        enable = 1'b1;
      end
      if ($urandom_range(0, 1) == 0) wait_drain(3000);
    end
    wait_drain(5000);

    chk("bytes_left", eb_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
